// File: rtl/mux3_3_pkg.sv
// Shared constants for the registered 3-to-1 multiplexer: select codes and
// the default data width.
package mux3_3_pkg;

  localparam int WIDTH_DEF = 3;

  localparam logic [1:0] SEL_E0  = 2'b00;
  localparam logic [1:0] SEL_E1  = 2'b01;
  localparam logic [1:0] SEL_E2  = 2'b10;
  localparam logic [1:0] SEL_INV = 2'b11;

endpackage : mux3_3_pkg

// File: rtl/mux3_3_comb.sv
// Combinational 3-to-1 select. The unused code, and any unknown select bits,
// produce all-zeros data and raise the invalid flag.
module mux3_3_comb
  import mux3_3_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] entrada0,
  input  logic [WIDTH-1:0] entrada1,
  input  logic [WIDTH-1:0] entrada2,
  input  logic [1:0]       controle,
  output logic [WIDTH-1:0] sel_data,
  output logic             sel_invalid
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch inferred.
    sel_data    = '0;
    sel_invalid = 1'b0;
    case (controle)
      SEL_E0:  sel_data = entrada0;
      SEL_E1:  sel_data = entrada1;
      SEL_E2:  sel_data = entrada2;
      default: begin
        sel_data    = '0;
        sel_invalid = 1'b1;
      end
    endcase
  end

endmodule : mux3_3_comb

// File: rtl/mux3_3.sv
// Registered 3-to-1 multiplexer: one-cycle latency from inputs to Resultado,
// with a registered flag for the unused select code.
module mux3_3
  import mux3_3_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Entrada0,
  input  logic [WIDTH-1:0] Entrada1,
  input  logic [WIDTH-1:0] Entrada2,
  input  logic [1:0]       Controle,
  output logic [WIDTH-1:0] Resultado,
  output logic             SelInvalido
);

  logic [WIDTH-1:0] resultado_d, resultado_q;
  logic             sel_invalido_d, sel_invalido_q;

  mux3_3_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .entrada0    (Entrada0),
    .entrada1    (Entrada1),
    .entrada2    (Entrada2),
    .controle    (Controle),
    .sel_data    (resultado_d),
    .sel_invalid (sel_invalido_d)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    // NOTE: non-blocking assignments keep flop updates order-independent.
    if (!Reset_n) begin
      resultado_q    <= '0;
      sel_invalido_q <= 1'b0;
    end else begin
      resultado_q    <= resultado_d;
      sel_invalido_q <= sel_invalido_d;
    end
  end

  // Outputs come straight from flops; no input-to-output combinational path.
  assign Resultado   = resultado_q;
  assign SelInvalido = sel_invalido_q;

endmodule : mux3_3

// File: tb/tb_mux3_3.sv
// Self-checking bench for mux3_3: table-driven vectors through a scoreboard
// queue, plus hand-written reset and sampling sequences, at WIDTH 3 and 8.
module tb_mux3_3;
  import mux3_3_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] e0, e1, e2, res;
  logic [1:0] ctl;
  logic       inv;
  logic [7:0] w0, w1, w2, wres;
  logic [1:0] wctl;
  logic       winv;

  mux3_3 #(.WIDTH(3)) dut3 (
    .Clock(clk), .Reset_n(rst_n), .Entrada0(e0), .Entrada1(e1), .Entrada2(e2),
    .Controle(ctl), .Resultado(res), .SelInvalido(inv)
  );

  mux3_3 #(.WIDTH(8)) dut8 (
    .Clock(clk), .Reset_n(rst_n), .Entrada0(w0), .Entrada1(w1), .Entrada2(w2),
    .Controle(wctl), .Resultado(wres), .SelInvalido(winv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ctl;
    logic [2:0] e0, e1, e2;
    logic [2:0] res;
    logic       inv;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       inv;
    bit         wide;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  // Reference for the wide instance, written from the select table.
  function automatic logic [8:0] model8(input logic [1:0] c, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] d);
    case (c)
      2'b00:   return {1'b0, a};
      2'b01:   return {1'b0, b};
      2'b10:   return {1'b0, d};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  task automatic compare_out(input string name);
    exp_t x;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 8'h01, 8'h00);
      return;
    end
    x = sb.pop_front();
    if (x.wide) begin
      check({name, "_res"}, wres, x.res);
      check({name, "_inv"}, {7'b0, winv}, {7'b0, x.inv});
    end else begin
      check({name, "_res"}, {5'b0, res}, x.res);
      check({name, "_inv"}, {7'b0, inv}, {7'b0, x.inv});
    end
  endtask

  task automatic drive3(input string name, input vec_t v);
    exp_t x;
    @(negedge clk);
    e0 = v.e0; e1 = v.e1; e2 = v.e2; ctl = v.ctl;
    x.res = {5'b0, v.res}; x.inv = v.inv; x.wide = 1'b0;
    sb.push_back(x);
    @(posedge clk);
    #1 compare_out(name);
  endtask

  task automatic drive8(input string name, input logic [1:0] c, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] d);
    exp_t       x;
    logic [8:0] m;
    @(negedge clk);
    w0 = a; w1 = b; w2 = d; wctl = c;
    m = model8(c, a, b, d);
    x.res = m[7:0]; x.inv = m[8]; x.wide = 1'b1;
    sb.push_back(x);
    @(posedge clk);
    #1 compare_out(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{ctl: 2'b00, e0: 3'b111, e1: 3'b010, e2: 3'b000, res: 3'b111, inv: 1'b0};
    vecs[1] = '{ctl: 2'b01, e0: 3'b111, e1: 3'b010, e2: 3'b000, res: 3'b010, inv: 1'b0};
    vecs[2] = '{ctl: 2'b10, e0: 3'b111, e1: 3'b010, e2: 3'b000, res: 3'b000, inv: 1'b0};
    vecs[3] = '{ctl: 2'b00, e0: 3'b111, e1: 3'b010, e2: 3'b000, res: 3'b111, inv: 1'b0};
    vecs[4] = '{ctl: 2'b11, e0: 3'b111, e1: 3'b010, e2: 3'b000, res: 3'b000, inv: 1'b1};
    vecs[5] = '{ctl: 2'b01, e0: 3'b111, e1: 3'b010, e2: 3'b000, res: 3'b010, inv: 1'b0};
    vecs[6] = '{ctl: 2'b10, e0: 3'b101, e1: 3'b110, e2: 3'b011, res: 3'b011, inv: 1'b0};
    vecs[7] = '{ctl: 2'b11, e0: 3'b101, e1: 3'b110, e2: 3'b011, res: 3'b000, inv: 1'b1};

    // Reset held with a live selection and a running clock.
    e0 = 3'b111; e1 = 3'b010; e2 = 3'b000; ctl = 2'b00;
    w0 = 8'hA5; w1 = 8'h3C; w2 = 8'hFF; wctl = 2'b11;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_hold_res", {5'b0, res}, 8'h00);
      check("rst_hold_inv", {7'b0, inv}, 8'h00);
      check("rst_hold_winv", {7'b0, winv}, 8'h00);
    end

    // Release away from an edge; the first edge loads the current selection.
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("rel_first_edge_res", {5'b0, res}, 8'h07);

    for (int i = 0; i < 8; i++) drive3($sformatf("vec%0d", i), vecs[i]);

    // Sampling: between-edge changes appear only at the next edge.
    drive3("lat_base", '{ctl: 2'b01, e0: 3'b111, e1: 3'b010, e2: 3'b000, res: 3'b010, inv: 1'b0});
    #2 e1 = 3'b101;
    #2 check("lat_hold_res", {5'b0, res}, 8'h02);
    @(posedge clk);
    #1 check("lat_update_res", {5'b0, res}, 8'h05);
    #2 e1 = 3'b000;
    #2 e1 = 3'b101;
    @(posedge clk);
    #1 check("glitch_res", {5'b0, res}, 8'h05);
    #2 ctl = 2'b11;
    #2 ctl = 2'b01;
    @(posedge clk);
    #1 check("ctl_glitch_inv", {7'b0, inv}, 8'h00);

    // Mid-cycle reset clears without a clock edge.
    drive3("mid_base", '{ctl: 2'b00, e0: 3'b111, e1: 3'b101, e2: 3'b000, res: 3'b111, inv: 1'b0});
    #2 rst_n = 1'b0;
    #1 check("mid_rst_async_res", {5'b0, res}, 8'h00);
    @(posedge clk);
    #1 check("mid_rst_held_res", {5'b0, res}, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("mid_rel_pre_edge_res", {5'b0, res}, 8'h00);
    @(posedge clk);
    #1 check("mid_rel_load_res", {5'b0, res}, 8'h07);

    // Wide instance: fixed sweep then a few random patterns.
    for (int c = 0; c < 4; c++)
      drive8($sformatf("w8_sel%0d", c), c[1:0], 8'hA5, 8'h3C, 8'hFF);
    for (int i = 0; i < 6; i++)
      drive8($sformatf("w8_rand%0d", i), 2'($urandom_range(0, 3)),
             8'($urandom), 8'($urandom), 8'($urandom));

    check("sb_drained", 8'(sb.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mux3_3

// File: doc/mux3_3.md
Name: mux3_3

Overview:
- Registered 3-to-1 multiplexer: routes one of three WIDTH-bit data inputs to a registered output, chosen by a 2-bit select.
- Used in the 8-bit processor datapath wherever a 3-bit field is chosen from three sources, such as register-address selection.
- Output is captured on the clock edge and cleared by an asynchronous active-low reset.
- Flags the one unused select code.

Parameters:
- WIDTH, 3, bit width of each data input and of Resultado.

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Entrada0  input  WIDTH  data source selected when Controle=00.
- Entrada1  input  WIDTH  data source selected when Controle=01.
- Entrada2  input  WIDTH  data source selected when Controle=10.
- Controle  input  2  select code.
- Resultado  output  WIDTH  registered selected data.
- SelInvalido  output  1  registered flag, high when the captured Controle was 11.

Behaviour:
- One clock, Clock; reset Reset_n is asynchronous and active-low.
- Reset:
  - Reset_n low forces Resultado=0 and SelInvalido=0 immediately, with no clock required.
  - Outputs stay at these values while Reset_n is low.
  - Reset asserted mid-operation discards any pending selection.
- Selection function, evaluated combinationally each cycle:
  - Controle=00 -> Entrada0.
  - Controle=01 -> Entrada1.
  - Controle=10 -> Entrada2.
  - Controle=11 -> all-zeros, with SelInvalido next value=1.
- Register update:
  - On each rising edge of Clock with Reset_n high, Resultado <= selection, and SelInvalido <= (Controle==2'b11).
  - Latency is exactly one clock from input or select change to output.
  - No enable; the register updates every cycle.
- Inputs sampled at the edge are the ones used. Changes of data inputs and select between edges have no effect on outputs.
- Release of Reset_n:
  - The first rising edge after Reset_n goes high loads the current selection.
  - Release coincident with an edge is not a valid timing; the bench keeps reset release at least 1 time unit away from edges.
- Unknown (X/Z) select bits: Resultado is driven to all-zeros and SelInvalido=1. This is the default-branch behaviour.
- The datapath is bitwise only: no arithmetic and no width conversion. Every data port is exactly WIDTH bits.
- Outputs are driven directly from flops; there is no combinational path from input to output.

Decomposition:
- Shared package holds:
  - select-code constants SEL_E0=2'b00, SEL_E1=2'b01, SEL_E2=2'b10, SEL_INV=2'b11;
  - the default WIDTH constant (3).
- One natural sub-module, mux3_3_comb: the purely combinational select, including zero output and invalid flag for code 11.
- The top, mux3_3, instantiates mux3_3_comb and adds the reset-able output register.

Test Plan:
- Reset: Reset_n=0 with Entrada0=111, Controle=00 and clock running -> Resultado=000 and SelInvalido=0 throughout reset, changing asynchronously at assertion.
- Select sweep:
  - Setup: Entrada0=111, Entrada1=010, Entrada2=000; Controle cycles 00,01,10,00, one value per clock.
  - Required: Resultado = 111, 010, 000, 111, each one clock after the corresponding Controle; SelInvalido=0 throughout.
- Invalid code: Controle=11 with Entrada values as above -> next edge Resultado=000, SelInvalido=1. Returning to Controle=01 -> next edge Resultado=010, SelInvalido=0.
- Latency/sampling:
  - Stimulus: Entrada1 toggles 010->101 between edges while Controle=01.
  - Required: Resultado unchanged until the next rising edge, then 101; a glitch that reverts before the edge never appears on the output.
- Mid-operation reset: assert Reset_n low mid-cycle while Resultado=111 -> Resultado=000 immediately. After release, the first edge loads the current selection.
- Parameter: WIDTH=8 with Entrada0=8'hA5, Entrada1=8'h3C, Entrada2=8'hFF -> select 00/01/10 yields A5/3C/FF after one clock each; 11 yields 00 with SelInvalido=1.
